mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the 5-stage pipeline; consumes the EX->MEM pipeline registers and produces the MEM->WB pipeline registers.
- Issues loads and stores on a single-outstanding data-bus request/acknowledge interface.
- Stalls the upstream pipeline while an access is pending and aborts accesses that are never acknowledged.

Parameters:
- ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, datapath width; the only supported value is 32.
- ACK_TIMEOUT, 255, maximum WAIT cycles before an access is aborted; range 1..255.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_data_mem  input  DATA_WIDTH  ALU result: the effective address for an access, else the writeback value.
- mem_we_mem  input  4  store byte enables (bit i = byte lane i); non-zero means store.
- reg_d_we_mem  input  1  destination register write enable.
- reg_d_addr_mem  input  ADDR_WIDTH  destination register.
- reg_d_data_sel_mem  input  1  1 = load (writeback data from memory), 0 = writeback ALU result.
- reg_t_data_mem  input  DATA_WIDTH  store data (rt).
- stall  output  1  combinational; 1 = upstream stages hold state and keep all *_mem inputs stable.
- dbus_req  output  1  access request.
- dbus_we  output  4  byte write enables; 0 = read.
- dbus_addr  output  DATA_WIDTH  word address: {alu_data_mem[31:2], 2'b00}.
- dbus_wdata  output  DATA_WIDTH  lane-replicated store data.
- dbus_ack  input  1  access complete; may arrive in the same cycle as the request.
- dbus_rdata  input  DATA_WIDTH  read data, valid when dbus_ack = 1.
- bus_err  output  1  registered one-cycle pulse on timeout abort.
- reg_d_we_wb  output  1  MEM->WB write enable.
- reg_d_addr_wb  output  ADDR_WIDTH  MEM->WB destination register.
- reg_d_data_wb  output  DATA_WIDTH  MEM->WB writeback data.

Behaviour:
- access = (mem_we_mem != 0) | reg_d_data_sel_mem.
- If mem_we_mem != 0 and reg_d_data_sel_mem = 1 together, the access is a store: dbus_we = mem_we_mem and no register writeback data comes from memory.
- dbus_we = mem_we_mem when dbus_req = 1; otherwise 0.
- Store data lane replication:
  - Single-lane enable (0001/0010/0100/1000): wdata = {4{rt[7:0]}}.
  - Enable 0011 or 1100: wdata = {2{rt[15:0]}}.
  - Any other pattern: wdata = rt unchanged.
- Loads are word loads. alu_data_mem[1:0] is ignored.
- FSM states are IDLE and WAIT, with an 8-bit wait counter.
- IDLE, access = 0:
  - dbus_req = 0, stall = 0.
  - Next edge registers the passthrough: reg_d_we_wb <= reg_d_we_mem, reg_d_data_wb <= alu_data_mem.
- IDLE, access = 1:
  - dbus_req = 1 combinationally.
  - If dbus_ack = 1: stall = 0, the access completes this cycle, and the state stays IDLE.
  - Else: stall = 1, next state is WAIT, counter <= 1.
- WAIT:
  - dbus_req = 1, with address, data and enables driven from the held inputs.
  - If dbus_ack = 1: complete, stall = 0, next state is IDLE.
  - Else if counter == ACK_TIMEOUT: abort. stall = 0, next state is IDLE, bus_err = 1 in the following cycle.
  - Else: stall = 1, counter increments.
- Completion, registered at the edge:
  - Load: reg_d_data_wb <= dbus_rdata.
  - Store: reg_d_data_wb <= alu_data_mem.
  - reg_d_we_wb <= reg_d_we_mem.
  - reg_d_addr_wb <= reg_d_addr_mem.
- Stalled cycle (stall = 1): the edge inserts a bubble. reg_d_we_wb <= 0; the other WB registers hold their values.
- Abort: bubble, reg_d_we_wb <= 0. The instruction is dropped and the pipeline advances.
- A dbus_ack arriving while dbus_req = 0 is ignored.
- Reset (asynchronous, at any time including mid-WAIT):
  - State returns to IDLE, counter = 0.
  - reg_d_we_wb = 0, reg_d_addr_wb = 0, reg_d_data_wb = 0, bus_err = 0.
  - dbus_req drops immediately.
- Latency: zero-wait access takes 1 cycle; an access acked N cycles after the request cycle takes N+1 cycles with N stall cycles.

Test Plan:
- Non-memory op, alu=0x1234, reg_d_addr=7, we_mem=1 -> no dbus_req, stall=0; next cycle reg_d_we_wb=1, addr=7, data=0x1234.
- Load with addr 0x103, ack at 2 cycles, rdata=0xCAFEBABE -> dbus_addr=0x100, stall high for 2 cycles with bubbles; then reg_d_data_wb=0xCAFEBABE, we_wb=1.
- Store byte, we=0100, rt=0x000000A5, same-cycle ack -> dbus_we=0100, wdata=0xA5A5A5A5, stall never asserted.
- Store half, we=1100, rt=0x0000BEEF -> wdata=0xBEEFBEEF; store with we=1111 -> wdata=rt unchanged.
- Load never acked, ACK_TIMEOUT=4 -> stall high exactly 4 cycles, then bus_err one-cycle pulse, reg_d_we_wb=0, following op proceeds normally.
- rst asserted in WAIT, 2nd cycle -> dbus_req=0 immediately, all WB outputs 0; after release, a new load completes normally.

Source files
------------

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access : memory stage of the 5-stage pipeline.
//
// Takes the EX->MEM pipeline registers and produces the MEM->WB pipeline
// registers. Loads and stores go out on a data bus that allows one request
// at a time and completes it with a request/acknowledge handshake. The stage
// stalls the upstream pipeline while an access waits for its acknowledge.
// An access that is not acknowledged within ACK_TIMEOUT wait cycles is
// dropped, and bus_err pulses for one cycle.
//
// Ports
//   clk, rst             pipeline clock, asynchronous active-high reset
//   alu_data_mem         effective address for an access, else writeback value
//   mem_we_mem           store byte enables (non-zero = store)
//   reg_d_we_mem         destination register write enable
//   reg_d_addr_mem       destination register
//   reg_d_data_sel_mem   1 = load, 0 = writeback ALU result
//   reg_t_data_mem       store data (rt)
//   stall                combinational hold request to the upstream stages
//   dbus_req/we/addr/wdata  data-bus request side
//   dbus_ack/rdata       data-bus completion side
//   bus_err              one-cycle pulse after a timeout abort
//   reg_d_we_wb/addr_wb/data_wb  MEM->WB pipeline registers
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] alu_data_mem,
  input  logic [3:0]            mem_we_mem,
  input  logic                  reg_d_we_mem,
  input  logic [ADDR_WIDTH-1:0] reg_d_addr_mem,
  input  logic                  reg_d_data_sel_mem,
  input  logic [DATA_WIDTH-1:0] reg_t_data_mem,
  output logic                  stall,
  output logic                  dbus_req,
  output logic [3:0]            dbus_we,
  output logic [DATA_WIDTH-1:0] dbus_addr,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  output logic                  bus_err,
  output logic                  reg_d_we_wb,
  output logic [ADDR_WIDTH-1:0] reg_d_addr_wb,
  output logic [DATA_WIDTH-1:0] reg_d_data_wb
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;

  logic access_s;
  logic is_load_s;
  logic req_s;
  logic stall_s;
  logic complete_s;
  logic abort_s;

  // Replicate store data so the addressed byte lanes carry the right bytes.
  function automatic logic [31:0] lane_rep(input logic [3:0] be, input logic [31:0] rt);
    logic [31:0] res;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: res = {4{rt[7:0]}};
      4'b0011, 4'b1100:                   res = {2{rt[15:0]}};
      default:                            res = rt;
    endcase
    return res;
  endfunction

  // A store takes priority over the load select when both are set.
  assign access_s  = (mem_we_mem != 4'b0000) | reg_d_data_sel_mem;
  assign is_load_s = reg_d_data_sel_mem & (mem_we_mem == 4'b0000);

  // Bus request and stall are forced low while reset is held, so an
  // in-flight request drops at once.
  assign dbus_req   = req_s & ~rst;
  assign stall      = stall_s & ~rst;
  assign dbus_we    = dbus_req ? mem_we_mem : 4'b0000;
  assign dbus_addr  = {alu_data_mem[DATA_WIDTH-1:2], 2'b00};
  assign dbus_wdata = lane_rep(mem_we_mem, reg_t_data_mem);

  // Next-state logic: access handshake, wait counting and timeout abort.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    complete_s  = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          req_s = 1'b1;
          if (dbus_ack) begin
            complete_s = 1'b1;
          end else begin
            stall_s     = 1'b1;
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = 8'd1;
          end
        end else begin
          req_s = 1'b0;
        end
      end
      ST_WAIT: begin
        req_s = 1'b1;
        if (dbus_ack) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else if (cnt_r == TIMEOUT_C) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // MEM->WB registers: a stall or abort inserts a bubble and holds the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err       <= 1'b0;
      reg_d_we_wb   <= 1'b0;
      reg_d_addr_wb <= '0;
      reg_d_data_wb <= '0;
    end else begin
      bus_err <= abort_s;
      if (stall_s || abort_s) begin
        reg_d_we_wb <= 1'b0;
      end else begin
        reg_d_we_wb   <= reg_d_we_mem;
        reg_d_addr_wb <= reg_d_addr_mem;
        reg_d_data_wb <= (complete_s && is_load_s) ? dbus_rdata : alu_data_mem;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access : directed bench for mem_access (ACK_TIMEOUT = 4).
// A behavioural model tracks how long the current access has been waiting
// and predicts the bus, stall and writeback outputs every cycle. Directed
// steps add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_data_mem;
  logic [3:0]  mem_we_mem;
  logic        reg_d_we_mem;
  logic [4:0]  reg_d_addr_mem;
  logic        reg_d_data_sel_mem;
  logic [31:0] reg_t_data_mem;
  logic        stall;
  logic        dbus_req;
  logic [3:0]  dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        bus_err;
  logic        reg_d_we_wb;
  logic [4:0]  reg_d_addr_wb;
  logic [31:0] reg_d_data_wb;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .alu_data_mem(alu_data_mem), .mem_we_mem(mem_we_mem),
    .reg_d_we_mem(reg_d_we_mem), .reg_d_addr_mem(reg_d_addr_mem),
    .reg_d_data_sel_mem(reg_d_data_sel_mem), .reg_t_data_mem(reg_t_data_mem),
    .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .bus_err(bus_err),
    .reg_d_we_wb(reg_d_we_wb), .reg_d_addr_wb(reg_d_addr_wb),
    .reg_d_data_wb(reg_d_data_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int          elapsed = 0;      // cycles the current access has waited
  logic        m_we_wb = 1'b0;
  logic [4:0]  m_addr_wb = 5'd0;
  logic [31:0] m_data_wb = 32'd0;
  logic        m_bus_err = 1'b0;

  always begin
    logic acc, st, done, ab, stl;
    logic [31:0] exp_wdata;
    @(negedge clk);
    #3;
    if (rst) begin
      chk("m_rst_req", {31'd0, dbus_req}, 32'd0);
      chk("m_rst_stall", {31'd0, stall}, 32'd0);
      chk("m_rst_we_wb", {31'd0, reg_d_we_wb}, 32'd0);
      chk("m_rst_addr_wb", {27'd0, reg_d_addr_wb}, 32'd0);
      chk("m_rst_data_wb", reg_d_data_wb, 32'd0);
      chk("m_rst_bus_err", {31'd0, bus_err}, 32'd0);
      elapsed = 0;
      m_we_wb = 1'b0; m_addr_wb = 5'd0; m_data_wb = 32'd0; m_bus_err = 1'b0;
    end else begin
      st   = (mem_we_mem != 4'b0000);
      acc  = st || reg_d_data_sel_mem;
      done = acc && dbus_ack;
      ab   = acc && !dbus_ack && (elapsed == TO);
      stl  = acc && !dbus_ack && (elapsed < TO);
      if ($countones(mem_we_mem) == 1)
        exp_wdata = {4{reg_t_data_mem[7:0]}};
      else if (mem_we_mem == 4'b0011 || mem_we_mem == 4'b1100)
        exp_wdata = {2{reg_t_data_mem[15:0]}};
      else
        exp_wdata = reg_t_data_mem;
      chk("m_req", {31'd0, dbus_req}, {31'd0, acc});
      chk("m_dbus_we", {28'd0, dbus_we}, acc ? {28'd0, mem_we_mem} : 32'd0);
      chk("m_stall", {31'd0, stall}, {31'd0, stl});
      if (acc) chk("m_addr", dbus_addr, alu_data_mem & ~32'd3);
      if (st)  chk("m_wdata", dbus_wdata, exp_wdata);
      chk("m_bus_err", {31'd0, bus_err}, {31'd0, m_bus_err});
      chk("m_we_wb", {31'd0, reg_d_we_wb}, {31'd0, m_we_wb});
      chk("m_addr_wb", {27'd0, reg_d_addr_wb}, {27'd0, m_addr_wb});
      chk("m_data_wb", reg_d_data_wb, m_data_wb);
      // predict what the next rising edge leaves in the WB registers
      m_bus_err = ab;
      if (stl || ab) begin
        m_we_wb = 1'b0;
      end else begin
        m_we_wb   = reg_d_we_mem;
        m_addr_wb = reg_d_addr_mem;
        m_data_wb = (done && !st) ? dbus_rdata : alu_data_mem;
      end
      elapsed = stl ? elapsed + 1 : 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic apply(input logic [3:0] we, input logic sel, input logic dwe,
                       input logic [4:0] da, input logic [31:0] alu,
                       input logic [31:0] rt, input logic ack, input logic [31:0] rd);
    @(negedge clk);
    mem_we_mem = we; reg_d_data_sel_mem = sel; reg_d_we_mem = dwe;
    reg_d_addr_mem = da; alu_data_mem = alu; reg_t_data_mem = rt;
    dbus_ack = ack; dbus_rdata = rd;
  endtask

  task automatic idle();
    apply(4'b0000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_we_mem = 4'b0000; reg_d_data_sel_mem = 1'b0; reg_d_we_mem = 1'b0;
    reg_d_addr_mem = 5'd0; alu_data_mem = 32'd0; reg_t_data_mem = 32'd0;
    dbus_ack = 1'b0; dbus_rdata = 32'd0;
    #1;
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_we_wb", {31'd0, reg_d_we_wb}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // non-memory op; a stray ack without a request must be ignored
    apply(4'b0000, 1'b0, 1'b1, 5'd7, 32'h0000_1234, 32'd0, 1'b1, 32'hDEAD_DEAD);
    #4 chk("nm_req", {31'd0, dbus_req}, 32'd0);
    chk("nm_stall", {31'd0, stall}, 32'd0);
    idle();
    #4 chk("nm_we_wb", {31'd0, reg_d_we_wb}, 32'd1);
    chk("nm_addr_wb", {27'd0, reg_d_addr_wb}, 32'd7);
    chk("nm_data_wb", reg_d_data_wb, 32'h0000_1234);

    // load at 0x103, ack two cycles after the request
    apply(4'b0000, 1'b1, 1'b1, 5'd9, 32'h0000_0103, 32'd0, 1'b0, 32'd0);
    #4 chk("ld_addr", dbus_addr, 32'h0000_0100);
    chk("ld_stall0", {31'd0, stall}, 32'd1);
    apply(4'b0000, 1'b1, 1'b1, 5'd9, 32'h0000_0103, 32'd0, 1'b0, 32'd0);
    #4 chk("ld_stall1", {31'd0, stall}, 32'd1);
    chk("ld_bubble", {31'd0, reg_d_we_wb}, 32'd0);
    apply(4'b0000, 1'b1, 1'b1, 5'd9, 32'h0000_0103, 32'd0, 1'b1, 32'hCAFE_BABE);
    #4 chk("ld_stall2", {31'd0, stall}, 32'd0);
    idle();
    #4 chk("ld_data_wb", reg_d_data_wb, 32'hCAFE_BABE);
    chk("ld_we_wb", {31'd0, reg_d_we_wb}, 32'd1);
    chk("ld_addr_wb", {27'd0, reg_d_addr_wb}, 32'd9);

    // stores with same-cycle ack
    apply(4'b0100, 1'b0, 1'b0, 5'd0, 32'h0000_2000, 32'h0000_00A5, 1'b1, 32'd0);
    #4 chk("sb_we", {28'd0, dbus_we}, 32'h4);
    chk("sb_wdata", dbus_wdata, 32'hA5A5_A5A5);
    chk("sb_stall", {31'd0, stall}, 32'd0);
    apply(4'b1100, 1'b0, 1'b0, 5'd0, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 32'd0);
    #4 chk("sh_wdata", dbus_wdata, 32'hBEEF_BEEF);
    apply(4'b1111, 1'b0, 1'b0, 5'd0, 32'h0000_2004, 32'h1234_5678, 1'b1, 32'd0);
    #4 chk("sw_wdata", dbus_wdata, 32'h1234_5678);
    // store enables together with load select: still a store, WB takes ALU
    apply(4'b0001, 1'b1, 1'b1, 5'd2, 32'h0000_0040, 32'h0000_0077, 1'b1, 32'hFFFF_FFFF);
    #4 chk("sl_wdata", dbus_wdata, 32'h7777_7777);
    idle();
    #4 chk("sl_data_wb", reg_d_data_wb, 32'h0000_0040);

    // load never acked: 4 stall cycles then abort
    for (int i = 0; i < TO; i++) begin
      apply(4'b0000, 1'b1, 1'b1, 5'd3, 32'h0000_0200, 32'd0, 1'b0, 32'd0);
      #4 chk("to_stall", {31'd0, stall}, 32'd1);
    end
    apply(4'b0000, 1'b1, 1'b1, 5'd3, 32'h0000_0200, 32'd0, 1'b0, 32'd0);
    #4 chk("to_abort_stall", {31'd0, stall}, 32'd0);
    chk("to_abort_req", {31'd0, dbus_req}, 32'd1);
    apply(4'b0000, 1'b0, 1'b1, 5'd4, 32'h0000_0055, 32'd0, 1'b0, 32'd0);
    #4 chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_we_wb", {31'd0, reg_d_we_wb}, 32'd0);

    // reset during WAIT, in the second cycle of the access
    apply(4'b0000, 1'b1, 1'b1, 5'd5, 32'h0000_0300, 32'd0, 1'b0, 32'd0);
    #4 chk("nx_bus_err", {31'd0, bus_err}, 32'd0);
    chk("nx_data_wb", reg_d_data_wb, 32'h0000_0055);
    chk("nx_addr_wb", {27'd0, reg_d_addr_wb}, 32'd4);
    apply(4'b0000, 1'b1, 1'b1, 5'd5, 32'h0000_0300, 32'd0, 1'b0, 32'd0);
    #2 rst = 1'b1;
    #1 chk("rw_req", {31'd0, dbus_req}, 32'd0);
    chk("rw_addr_wb", {27'd0, reg_d_addr_wb}, 32'd0);
    chk("rw_data_wb", reg_d_data_wb, 32'd0);
    idle();
    idle();
    rst = 1'b0;
    apply(4'b0000, 1'b1, 1'b1, 5'd6, 32'h0000_0104, 32'd0, 1'b0, 32'd0);
    apply(4'b0000, 1'b1, 1'b1, 5'd6, 32'h0000_0104, 32'd0, 1'b1, 32'h1122_3344);
    idle();
    #4 chk("rl_data_wb", reg_d_data_wb, 32'h1122_3344);
    chk("rl_we_wb", {31'd0, reg_d_we_wb}, 32'd1);
    chk("rl_addr_wb", {27'd0, reg_d_addr_wb}, 32'd6);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
